// File: rtl/gold_output_arbiter.sv
// rtl/gold_output_arbiter.sv - gold ring router output port: two-VC buffer pair, per-VC round-robin, hop rewrite
module gold_output_arbiter #(
  parameter int DW        = 64,
  parameter int HOP_LSB   = 18,
  parameter bit SHIFT_HOP = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          polarity,
  input  logic          req_a,
  input  logic [DW-1:0] pkt_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [DW-1:0] pkt_b,
  output logic          gnt_b,
  output logic          so,
  output logic [DW-1:0] dout,
  input  logic          ro,
  output logic [1:0]    ob_full
);

  logic          vi;
  logic          ve;
  logic [1:0]    prio;
  logic [1:0]    full_q;
  logic [DW-1:0] ob_data [2];
  logic [DW-1:0] sel_pkt;
  logic [DW-1:0] wr_pkt;

  // The internal VC is written this cycle while the other one drains, so the
  // two buffers never see a write and a drain together.
  assign vi = polarity;
  assign ve = ~polarity;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset && !full_q[vi]) begin
      if (req_a && req_b) begin
        gnt_a = ~prio[vi];
        gnt_b = prio[vi];
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign sel_pkt = gnt_b ? pkt_b : pkt_a;

  // Ring outputs consume one hop as the packet is buffered.
  always_comb begin
    wr_pkt = sel_pkt;
    if (SHIFT_HOP) begin
      wr_pkt[HOP_LSB +: 8] = {1'b0, sel_pkt[HOP_LSB+1 +: 7]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q     <= 2'b00;
      prio       <= 2'b00;
      ob_data[0] <= '0;
      ob_data[1] <= '0;
    end else begin
      if (gnt_a || gnt_b) begin
        ob_data[vi] <= wr_pkt;
        full_q[vi]  <= 1'b1;
        prio[vi]    <= gnt_a;
      end
      if (so && ro) begin
        full_q[ve] <= 1'b0;
      end
    end
  end

  assign so      = full_q[ve];
  assign dout    = so ? ob_data[ve] : '0;
  assign ob_full = full_q;

endmodule

// File: tb/tb_gold_output_arbiter.sv
// tb/tb_gold_output_arbiter.sv - vector-table bench for gold_output_arbiter
module tb_gold_output_arbiter;

  localparam logic [63:0] P   = 64'h0000_0000_00C0_0000;
  localparam logic [63:0] PS  = 64'h0000_0000_0060_0000;
  localparam logic [63:0] PA  = 64'hA5A5_0000_0000_00AA;
  localparam logic [63:0] PB  = 64'h5A5A_0000_0000_00BB;
  localparam logic [63:0] F   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FS  = 64'hFFFF_FFFF_FDFF_FFFF;
  localparam logic [63:0] Z   = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        polarity = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [63:0] pkt_a = '0;
  logic [63:0] pkt_b = '0;
  logic        ro = 1'b1;

  logic        gnt_a1, gnt_b1, so1;
  logic [63:0] dout1;
  logic [1:0]  full1;
  logic        gnt_a0, gnt_b0, so0;
  logic [63:0] dout0;
  logic [1:0]  full0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst, pol, ra, rb;
    logic [63:0] pa, pb;
    logic        ro;
    logic        ga, gb, so;
    logic [63:0] dout;
    logic [1:0]  full;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  gold_output_arbiter #(.DW(64), .HOP_LSB(18), .SHIFT_HOP(1'b1)) u1 (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req_a(req_a), .pkt_a(pkt_a), .gnt_a(gnt_a1),
    .req_b(req_b), .pkt_b(pkt_b), .gnt_b(gnt_b1),
    .so(so1), .dout(dout1), .ro(ro), .ob_full(full1)
  );

  gold_output_arbiter #(.DW(64), .HOP_LSB(18), .SHIFT_HOP(1'b0)) u0 (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req_a(req_a), .pkt_a(pkt_a), .gnt_a(gnt_a0),
    .req_b(req_b), .pkt_b(pkt_b), .gnt_b(gnt_b0),
    .so(so0), .dout(dout0), .ro(ro), .ob_full(full0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, pol, ra, rb, input logic [63:0] pa, pb,
                     input logic r, ga, gb, s, input logic [63:0] d, input logic [1:0] f);
    vec_t v;
    v.rst = rst; v.pol = pol; v.ra = ra; v.rb = rb; v.pa = pa; v.pb = pb;
    v.ro = r; v.ga = ga; v.gb = gb; v.so = s; v.dout = d; v.full = f;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, pol, ra, rb, input logic [63:0] pa, pb, input logic r);
    reset = rst; polarity = pol; req_a = ra; req_b = rb; pkt_a = pa; pkt_b = pb; ro = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst pol ra rb pa  pb  ro  ga gb so dout full
    add(0, 0, 1, 1, PA, PB, 1, 0, 0, 0, Z,  2'b00);
    add(0, 1, 1, 0, PA, Z,  1, 0, 0, 0, Z,  2'b00);
    add(1, 0, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);
    add(1, 1, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);
    add(1, 0, 1, 0, P,  Z,  1, 1, 0, 0, Z,  2'b00);
    add(1, 1, 0, 0, Z,  Z,  1, 0, 0, 1, PS, 2'b01);
    add(1, 0, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);
    add(0, 1, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);
    add(1, 0, 1, 1, PA, PB, 1, 1, 0, 0, Z,  2'b00);
    add(1, 1, 1, 1, PA, PB, 1, 1, 0, 1, PA, 2'b01);
    add(1, 0, 1, 1, PA, PB, 1, 0, 1, 1, PA, 2'b10);
    add(1, 1, 1, 1, PA, PB, 1, 0, 1, 1, PB, 2'b01);
    add(1, 0, 1, 1, PA, PB, 1, 1, 0, 1, PB, 2'b10);
    add(1, 1, 1, 1, PA, PB, 1, 1, 0, 1, PA, 2'b01);
    add(1, 0, 0, 0, Z,  Z,  1, 0, 0, 1, PA, 2'b10);
    add(1, 1, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);
    add(1, 0, 1, 0, P,  Z,  0, 1, 0, 0, Z,  2'b00);
    add(1, 1, 0, 0, Z,  Z,  0, 0, 0, 1, PS, 2'b01);
    add(1, 0, 0, 1, Z,  PB, 0, 0, 0, 0, Z,  2'b01);
    add(1, 1, 0, 0, Z,  Z,  0, 0, 0, 1, PS, 2'b01);
    add(1, 0, 0, 1, Z,  PB, 0, 0, 0, 0, Z,  2'b01);
    add(1, 1, 0, 0, Z,  Z,  1, 0, 0, 1, PS, 2'b01);
    add(1, 0, 0, 1, Z,  PB, 1, 0, 1, 0, Z,  2'b00);
    add(1, 1, 0, 0, Z,  Z,  1, 0, 0, 1, PB, 2'b01);
    add(1, 0, 0, 0, Z,  Z,  1, 0, 0, 0, Z,  2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pol, vecs[i].ra, vecs[i].rb, vecs[i].pa, vecs[i].pb, vecs[i].ro);
      #1;
      check($sformatf("v%0d gnt_a", i), {63'b0, gnt_a1}, {63'b0, vecs[i].ga});
      check($sformatf("v%0d gnt_b", i), {63'b0, gnt_b1}, {63'b0, vecs[i].gb});
      check($sformatf("v%0d so", i),    {63'b0, so1},    {63'b0, vecs[i].so});
      check($sformatf("v%0d dout", i),  dout1,           vecs[i].dout);
      check($sformatf("v%0d ob_full", i), {62'b0, full1}, {62'b0, vecs[i].full});
      tick();
    end

    // Unshifted instance passes the hop field through untouched.
    drive(1, 1, 0, 1, Z, F, 1);
    #1;
    check("noshift gnt_b", {63'b0, gnt_b0}, 64'd1);
    tick();
    drive(1, 0, 0, 0, Z, Z, 1);
    #1;
    check("noshift so", {63'b0, so0}, 64'd1);
    check("noshift dout", dout0, F);
    check("shift dout all-ones", dout1, FS);
    tick();

    // Fill both buffers with the link stalled, then reset asynchronously.
    drive(1, 0, 1, 1, PA, PB, 0);
    #1;
    check("fill even gnt_a", {63'b0, gnt_a1}, 64'd1);
    tick();
    drive(1, 1, 1, 1, PA, PB, 0);
    #1;
    check("fill odd gnt_a", {63'b0, gnt_a1}, 64'd1);
    tick();
    drive(1, 0, 1, 1, PA, PB, 0);
    #1;
    check("full ob_full", {62'b0, full1}, 64'd3);
    check("full so", {63'b0, so1}, 64'd1);
    check("full dout", dout1, PA);
    check("full blocks gnt_a", {63'b0, gnt_a1}, 64'd0);
    check("full blocks gnt_b", {63'b0, gnt_b1}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async rst so", {63'b0, so1}, 64'd0);
    check("async rst dout", dout1, Z);
    check("async rst ob_full", {62'b0, full1}, 64'd0);
    check("async rst gnt_a", {63'b0, gnt_a1}, 64'd0);
    check("async rst gnt_b", {63'b0, gnt_b1}, 64'd0);
    check("async rst u0 ob_full", {62'b0, full0}, 64'd0);
    #1;
    drive(1, 0, 1, 1, PA, PB, 1);
    #1;
    check("post rst even gnt_a", {63'b0, gnt_a1}, 64'd1);
    check("post rst even gnt_b", {63'b0, gnt_b1}, 64'd0);
    tick();
    drive(1, 1, 1, 1, PA, PB, 1);
    #1;
    check("post rst odd gnt_a", {63'b0, gnt_a1}, 64'd1);
    check("post rst odd gnt_b", {63'b0, gnt_b1}, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gold_output_arbiter.md
Name: gold_output_arbiter

Overview:
- One output port of the gold ring router (CW, CCW or PE output); the router instantiates three.
- Shares one output buffer pair (even VC, odd VC, one 64-bit entry each) between the two input channels that can route to this output.
- Grants one requester per cycle using per-VC round-robin and rewrites the hop field for ring outputs.
- Drives the downstream send/ready link, alternating virtual channels with the router polarity.

Parameters:
- DW, 64, packet width.
- HOP_LSB, 18, LSB of the 8-bit hop field (bits HOP_LSB+7:HOP_LSB).
- SHIFT_HOP, 1, 1 = logically shift the hop field right by one when buffering (CW/CCW outputs); 0 = pass unchanged (PE output).

Ports:
- clk  in  1  router clock.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  router polarity: 0 = even cycle, 1 = odd cycle.
- req_a  in  1  requester A (lower-index input channel) has a packet for this output.
- pkt_a  in  DW  packet from requester A.
- gnt_a  out  1  A's packet is written at this clock edge.
- req_b  in  1  requester B has a packet for this output.
- pkt_b  in  DW  packet from requester B.
- gnt_b  out  1  B's packet is written at this clock edge.
- so  out  1  send valid to downstream.
- dout  out  DW  send data.
- ro  in  1  downstream ready.
- ob_full  out  2  [0] even buffer full, [1] odd buffer full.

Behaviour:
- Phases: internal VC vi = polarity; external VC ve = ~polarity. With polarity=0, the even buffer is written and the odd buffer is sent; with polarity=1, the reverse. A buffer is never written and drained in the same cycle.
- Grant (combinational; gnt_a and gnt_b are never both 1):
  - No grant when reset is low.
  - No grant when ob_full[vi]=1.
  - Otherwise, if only one of req_a/req_b is high, that requester is granted.
  - If both are high, the requester indicated by prio[vi] is granted (0=A, 1=B).
- Write on posedge when a grant is high: buf[vi] <= granted packet; ob_full[vi] <= 1.
  - SHIFT_HOP=1: the hop field is stored as {1'b0, hop[7:1]}; all other bits are unchanged.
  - SHIFT_HOP=0: the packet is stored unchanged.
- Round-robin: on a grant, prio[vi] <= the non-granted requester. The counter is updated even when only one requester was active. With no grant, prio is unchanged. prio[0] and prio[1] are independent.
- Requester contract: hold req and pkt stable until its gnt is seen; deassert req the cycle after the grant. The arbiter does not queue requests.
- Send (combinational from registers):
  - so = ob_full[ve].
  - dout = buf[ve] when so=1; dout = 0 when so=0.
- Drain: on posedge with so=1 and ro=1, ob_full[ve] <= 0. Buffer data is retained but does not matter.
- Stall: with so=1 and ro=0, the buffer stays full. The packet is re-offered the next time its VC is external, i.e. every other cycle.
- Latency:
  - Grant to write: same edge.
  - Write to earliest so: next cycle (polarity has toggled, so the written VC is now external).
- Full blocking: a full internal-VC buffer blocks both requesters. prio does not change while blocked.
- Reset (asynchronous assert, synchronous-safe deassert):
  - ob_full=2'b00, buf=0, prio=2'b00 (A first).
  - so=0, dout=0, gnt_a=gnt_b=0.
  - Reset asserted mid-transfer discards buffered packets. No partial state survives.
- polarity is owned by the router. This block never toggles it and makes no assumption about its value after reset.

Test Plan:
- Reset low then high, polarity toggling, no requests -> so=0, dout=0, ob_full=00, gnt_a=gnt_b=0 every cycle.
- polarity=0, req_a=1, pkt_a=64'h0000_0000_00C0_0000 (hop=8'h30), ro=1 -> gnt_a=1; next cycle (polarity=1) so=1, dout hop field=8'h18 (SHIFT_HOP=1), rest of packet equal; following edge ob_full=00.
- req_a=req_b=1 held, both buffers free, ro=1 -> even-VC grants alternate A,B,A,B on successive even cycles; odd-VC grants alternate independently starting with A.
- ro=0, polarity=0, single write from A -> ob_full[0]=1; subsequent even-cycle requests from B get gnt_b=0; so=1 only on odd cycles; set ro=1 -> drained, then gnt_b=1 on the next even cycle.
- SHIFT_HOP=0 instance, pkt_b=64'hFFFF_FFFF_FFFF_FFFF -> dout=64'hFFFF_FFFF_FFFF_FFFF unchanged.
- Reset pulsed low while ob_full=11 and so=1 -> so, dout and ob_full clear immediately (asynchronous); after release the first tied request is granted to A.
